// File: rtl/droic_cpld_top.sv
// DROIC v3 CPLD timing controller.
// After reset it programs six SPI bias pots, shifts a configuration word into the ROIC, then
// loops over 8 rows: row select, integrate, transfer, ADC convert, serialise to host.
// Ports:
//   OSC_in, pushbutton        system clock, synchronous active-high reset
//   ADSout1..8, ADSout15      ADC serial data in, MSB first
//   Rst, PhaseA*, PhaseC*     ROIC reset and integration/transfer phases
//   RS1..RS8                  one-hot row select
//   Sin*, Clk1..Clk4          ROIC config data/shift clock
//   ADRst*, ADMode_*, ADMode1_*, ADClk*, Sout1..4   ADC control and registered data copy
//   ClkOut, DataOut           host serial link
//   ResCS*, ResClk, ResSDI*   pot SPI (chip selects active-low)
//   DebugP2, DebugP3          frame-start pulse, conversion-active strobe
module droic_cpld_top #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [15:0] POT_VAL   = 16'h0180,
  parameter logic [15:0] CFG_WORD  = 16'hA5C3,
  parameter int unsigned INT_TICKS = 32,
  parameter int unsigned ADC_BITS  = 12
) (
  input  logic OSC_in,
  input  logic pushbutton,
  input  logic ADSout1,
  input  logic ADSout2,
  input  logic ADSout3,
  input  logic ADSout4,
  input  logic ADSout5,
  input  logic ADSout6,
  input  logic ADSout7,
  input  logic ADSout8,
  input  logic ADSout15,
  output logic Rst,
  output logic PhaseA1,
  output logic PhaseA2,
  output logic PhaseA4,
  output logic PhaseC1,
  output logic PhaseC2,
  output logic PhaseC3,
  output logic PhaseC4,
  output logic RS1,
  output logic RS2,
  output logic RS3,
  output logic RS4,
  output logic RS5,
  output logic RS6,
  output logic RS7,
  output logic RS8,
  output logic Sin1,
  output logic Sin2,
  output logic Sin3,
  output logic Sin4,
  output logic Sin5,
  output logic Sin6,
  output logic Sin7,
  output logic Sin8,
  output logic Sin9,
  output logic Sin10,
  output logic Sin11,
  output logic Sin12,
  output logic Sin14,
  output logic Sin15,
  output logic Sin16,
  output logic Clk1,
  output logic Clk2,
  output logic Clk3,
  output logic Clk4,
  output logic ADRst1,
  output logic ADRst2,
  output logic ADRst3,
  output logic ADMode_1,
  output logic ADMode_2,
  output logic ADMode_3,
  output logic ADMode1_1,
  output logic ADMode1_2,
  output logic ADMode1_3,
  output logic ADClk1,
  output logic ADClk2,
  output logic ADClk3,
  output logic Sout1,
  output logic Sout2,
  output logic Sout3,
  output logic Sout4,
  output logic ClkOut,
  output logic DataOut,
  output logic ResCS3,
  output logic ResCS4,
  output logic ResCS5,
  output logic ResCS6,
  output logic ResCS7,
  output logic ResCS9,
  output logic ResClk,
  output logic ResSDI1,
  output logic ResSDI2,
  output logic DebugP2,
  output logic DebugP3
);

  localparam int unsigned NumCh   = 9;
  localparam int unsigned OutBits = NumCh * ADC_BITS;
  localparam int unsigned IdxW    = $clog2(OutBits);

  localparam logic [7:0]      DivLast  = 8'(CLK_DIV - 1);
  localparam logic [15:0]     RstLast  = 16'd15;
  localparam logic [15:0]     SerLast  = 16'd32;  // 16 bits x 2 ticks, then one idle tick
  localparam logic [15:0]     RowLast  = 16'd1;
  localparam logic [15:0]     IntLast  = 16'(INT_TICKS - 1);
  localparam logic [15:0]     XferLast = 16'd3;
  localparam logic [15:0]     ConvLast = 16'(2 * ADC_BITS);  // 1 reset tick + 2 ticks per bit
  localparam logic [15:0]     OutLast  = 16'(2 * OutBits - 1);
  localparam logic [IdxW-1:0] OutMsb   = IdxW'(OutBits - 1);

  typedef enum logic [2:0] {StRst, StPot, StCfg, StRow, StInt, StXfer, StConv, StOut} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  pot_q, pot_d;
  logic [2:0]  row_q, row_d;
  logic        tick;

  logic [ADC_BITS-1:0] sh_q [NumCh];
  logic [ADC_BITS-1:0] sh_d [NumCh];
  logic [NumCh-1:0]    ads;
  logic [OutBits-1:0]  stream;
  logic [IdxW-1:0]     out_idx;
  logic [3:0]          bit_idx;
  logic                adc_rise;

  logic       rst_q, rst_d, adrst_q, adrst_d, res_clk_q, res_clk_d, res_sdi_q, res_sdi_d;
  logic       sin_q, sin_d, cfg_clk_q, cfg_clk_d, pha_q, pha_d, phc_q, phc_d;
  logic       admode_q, admode_d, adclk_q, adclk_d, clk_out_q, clk_out_d;
  logic       data_out_q, data_out_d, dbg2_q, dbg2_d, dbg3_q, dbg3_d;
  logic [5:0] cs_q, cs_d;
  logic [7:0] rs_q, rs_d;
  logic [3:0] sout_q, sout_d;

  assign ads  = {ADSout15, ADSout8, ADSout7, ADSout6, ADSout5, ADSout4, ADSout3, ADSout2,
                 ADSout1};
  assign tick = (div_q == DivLast);

  always_comb begin
    div_d = tick ? 8'd0 : div_q + 8'd1;
  end

  // Sequencer: cnt counts ticks since entering the current state (or current pot).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pot_d   = pot_q;
    row_d   = row_q;
    if (tick) begin
      cnt_d = cnt_q + 16'd1;
      unique case (state_q)
        StRst: if (cnt_q == RstLast) begin
          state_d = StPot;
          cnt_d   = '0;
        end
        StPot: if (cnt_q == SerLast) begin
          cnt_d = '0;
          if (pot_q == 3'd5) begin
            state_d = StCfg;
            pot_d   = '0;
          end else begin
            pot_d = pot_q + 3'd1;
          end
        end
        StCfg: if (cnt_q == SerLast) begin
          state_d = StRow;
          cnt_d   = '0;
        end
        StRow: if (cnt_q == RowLast) begin
          state_d = StInt;
          cnt_d   = '0;
        end
        StInt: if (cnt_q == IntLast) begin
          state_d = StXfer;
          cnt_d   = '0;
        end
        StXfer: if (cnt_q == XferLast) begin
          state_d = StConv;
          cnt_d   = '0;
        end
        StConv: if (cnt_q == ConvLast) begin
          state_d = StOut;
          cnt_d   = '0;
        end
        StOut: if (cnt_q == OutLast) begin
          state_d = StRow;
          cnt_d   = '0;
          row_d   = row_q + 3'd1;  // 3-bit row wraps 7 -> 0
        end
        default: begin
          state_d = StRst;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ADC clock rises on even, non-zero conversion steps; capture data on that same tick.
  assign adc_rise = tick && (state_d == StConv) && (cnt_d != '0) && !cnt_d[0];

  always_comb begin
    sh_d   = sh_q;
    sout_d = sout_q;
    if (adc_rise) begin
      for (int i = 0; i < NumCh; i++) begin
        sh_d[i] = {sh_q[i][ADC_BITS-2:0], ads[i]};
      end
      sout_d = ads[3:0];
    end
  end

  // Host stream: channel 1 first, channel 15 last, each MSB first.
  always_comb begin
    stream = '0;
    for (int i = 0; i < NumCh; i++) begin
      stream[(NumCh-1-i)*ADC_BITS +: ADC_BITS] = sh_q[i];
    end
  end

  // Outputs are decoded from the state being entered so they register together with it.
  always_comb begin
    rst_d      = 1'b0;
    adrst_d    = 1'b0;
    cs_d       = 6'h3F;
    res_clk_d  = 1'b0;
    res_sdi_d  = 1'b0;
    sin_d      = 1'b0;
    cfg_clk_d  = 1'b0;
    rs_d       = '0;
    pha_d      = 1'b0;
    phc_d      = 1'b0;
    admode_d   = 1'b0;
    adclk_d    = 1'b0;
    clk_out_d  = 1'b0;
    data_out_d = 1'b0;
    dbg2_d     = 1'b0;
    dbg3_d     = 1'b0;
    bit_idx    = 4'hF - cnt_d[4:1];
    out_idx    = OutMsb - cnt_d[IdxW:1];
    unique case (state_d)
      StRst: begin
        rst_d   = 1'b1;
        adrst_d = 1'b1;
      end
      StPot: begin
        rst_d   = 1'b1;
        adrst_d = 1'b1;
        if (cnt_d < SerLast) begin
          cs_d      = ~(6'b1 << pot_d);
          res_clk_d = cnt_d[0];
          res_sdi_d = POT_VAL[bit_idx];
        end
      end
      StCfg: begin
        adrst_d = 1'b1;
        if (cnt_d < SerLast) begin
          rst_d     = 1'b1;
          cfg_clk_d = cnt_d[0];
          sin_d     = CFG_WORD[bit_idx];
        end
      end
      StRow: begin
        rs_d   = 8'b1 << row_d;
        dbg2_d = (row_d == 3'd0) && (cnt_d == '0);
      end
      StInt: begin
        rs_d  = 8'b1 << row_d;
        pha_d = 1'b1;
      end
      StXfer: begin
        rs_d  = 8'b1 << row_d;
        phc_d = 1'b1;
      end
      StConv: begin
        rs_d     = 8'b1 << row_d;
        dbg3_d   = 1'b1;
        admode_d = 1'b1;
        adrst_d  = (cnt_d == '0);
        adclk_d  = (cnt_d != '0) && !cnt_d[0];
      end
      StOut: begin
        rs_d       = 8'b1 << row_d;
        clk_out_d  = cnt_d[0];
        data_out_d = stream[out_idx];
      end
      default: begin
        rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge OSC_in) begin
    if (pushbutton) begin
      div_q      <= '0;
      state_q    <= StRst;
      cnt_q      <= '0;
      pot_q      <= '0;
      row_q      <= '0;
      sh_q       <= '{default: '0};
      sout_q     <= '0;
      rst_q      <= 1'b1;
      adrst_q    <= 1'b1;
      cs_q       <= 6'h3F;
      res_clk_q  <= 1'b0;
      res_sdi_q  <= 1'b0;
      sin_q      <= 1'b0;
      cfg_clk_q  <= 1'b0;
      rs_q       <= '0;
      pha_q      <= 1'b0;
      phc_q      <= 1'b0;
      admode_q   <= 1'b0;
      adclk_q    <= 1'b0;
      clk_out_q  <= 1'b0;
      data_out_q <= 1'b0;
      dbg2_q     <= 1'b0;
      dbg3_q     <= 1'b0;
    end else begin
      div_q   <= div_d;
      sh_q    <= sh_d;
      sout_q  <= sout_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pot_q   <= pot_d;
      row_q   <= row_d;
      if (tick) begin
        rst_q      <= rst_d;
        adrst_q    <= adrst_d;
        cs_q       <= cs_d;
        res_clk_q  <= res_clk_d;
        res_sdi_q  <= res_sdi_d;
        sin_q      <= sin_d;
        cfg_clk_q  <= cfg_clk_d;
        rs_q       <= rs_d;
        pha_q      <= pha_d;
        phc_q      <= phc_d;
        admode_q   <= admode_d;
        adclk_q    <= adclk_d;
        clk_out_q  <= clk_out_d;
        data_out_q <= data_out_d;
        dbg2_q     <= dbg2_d;
        dbg3_q     <= dbg3_d;
      end
    end
  end

  assign Rst       = rst_q;
  assign PhaseA1   = pha_q;
  assign PhaseA2   = pha_q;
  assign PhaseA4   = pha_q;
  assign PhaseC1   = phc_q;
  assign PhaseC2   = phc_q;
  assign PhaseC3   = phc_q;
  assign PhaseC4   = phc_q;
  assign {RS8, RS7, RS6, RS5, RS4, RS3, RS2, RS1} = rs_q;
  assign {Sin1, Sin2, Sin3, Sin4, Sin5, Sin6, Sin7, Sin8} = {8{sin_q}};
  assign {Sin9, Sin10, Sin11, Sin12, Sin14, Sin15, Sin16} = {7{sin_q}};
  assign {Clk1, Clk2, Clk3, Clk4} = {4{cfg_clk_q}};
  assign {ADRst1, ADRst2, ADRst3} = {3{adrst_q}};
  assign {ADMode_1, ADMode_2, ADMode_3} = {3{admode_q}};
  assign {ADMode1_1, ADMode1_2, ADMode1_3} = 3'b000;
  assign {ADClk1, ADClk2, ADClk3} = {3{adclk_q}};
  assign {Sout4, Sout3, Sout2, Sout1} = sout_q;
  assign ClkOut    = clk_out_q;
  assign DataOut   = data_out_q;
  assign {ResCS9, ResCS7, ResCS6, ResCS5, ResCS4, ResCS3} = cs_q;
  assign ResClk    = res_clk_q;
  assign ResSDI1   = res_sdi_q;
  assign ResSDI2   = res_sdi_q;
  assign DebugP2   = dbg2_q;
  assign DebugP3   = dbg3_q;

endmodule

// File: tb/tb_droic_cpld_top.sv
// Self-checking bench for droic_cpld_top: decodes the serial links and phase timing at
// transaction level and compares against values derived from the sequencer's rules.
module tb_droic_cpld_top;

  logic OSC_in = 1'b0;
  logic pushbutton = 1'b1;
  logic [8:0] ads = '0;  // [0]=ADSout1 .. [7]=ADSout8, [8]=ADSout15

  logic Rst, PhaseA1, PhaseA2, PhaseA4, PhaseC1, PhaseC2, PhaseC3, PhaseC4;
  logic RS1, RS2, RS3, RS4, RS5, RS6, RS7, RS8;
  logic Sin1, Sin2, Sin3, Sin4, Sin5, Sin6, Sin7, Sin8, Sin9, Sin10, Sin11, Sin12;
  logic Sin14, Sin15, Sin16, Clk1, Clk2, Clk3, Clk4;
  logic ADRst1, ADRst2, ADRst3, ADMode_1, ADMode_2, ADMode_3;
  logic ADMode1_1, ADMode1_2, ADMode1_3, ADClk1, ADClk2, ADClk3;
  logic Sout1, Sout2, Sout3, Sout4, ClkOut, DataOut;
  logic ResCS3, ResCS4, ResCS5, ResCS6, ResCS7, ResCS9, ResClk, ResSDI1, ResSDI2;
  logic DebugP2, DebugP3;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] adc_w [9];

  logic [7:0]  rs_bus;
  logic [5:0]  cs_bus;
  logic [14:0] sin_all;
  logic [3:0]  cfgclk_all;
  logic [3:0]  sout_bus;
  assign rs_bus     = {RS8, RS7, RS6, RS5, RS4, RS3, RS2, RS1};
  assign cs_bus     = {ResCS9, ResCS7, ResCS6, ResCS5, ResCS4, ResCS3};
  assign sin_all    = {Sin1, Sin2, Sin3, Sin4, Sin5, Sin6, Sin7, Sin8, Sin9, Sin10, Sin11,
                       Sin12, Sin14, Sin15, Sin16};
  assign cfgclk_all = {Clk1, Clk2, Clk3, Clk4};
  assign sout_bus   = {Sout4, Sout3, Sout2, Sout1};

  droic_cpld_top dut (
    .OSC_in(OSC_in), .pushbutton(pushbutton),
    .ADSout1(ads[0]), .ADSout2(ads[1]), .ADSout3(ads[2]), .ADSout4(ads[3]),
    .ADSout5(ads[4]), .ADSout6(ads[5]), .ADSout7(ads[6]), .ADSout8(ads[7]),
    .ADSout15(ads[8]),
    .Rst(Rst), .PhaseA1(PhaseA1), .PhaseA2(PhaseA2), .PhaseA4(PhaseA4),
    .PhaseC1(PhaseC1), .PhaseC2(PhaseC2), .PhaseC3(PhaseC3), .PhaseC4(PhaseC4),
    .RS1(RS1), .RS2(RS2), .RS3(RS3), .RS4(RS4), .RS5(RS5), .RS6(RS6), .RS7(RS7), .RS8(RS8),
    .Sin1(Sin1), .Sin2(Sin2), .Sin3(Sin3), .Sin4(Sin4), .Sin5(Sin5), .Sin6(Sin6),
    .Sin7(Sin7), .Sin8(Sin8), .Sin9(Sin9), .Sin10(Sin10), .Sin11(Sin11), .Sin12(Sin12),
    .Sin14(Sin14), .Sin15(Sin15), .Sin16(Sin16),
    .Clk1(Clk1), .Clk2(Clk2), .Clk3(Clk3), .Clk4(Clk4),
    .ADRst1(ADRst1), .ADRst2(ADRst2), .ADRst3(ADRst3),
    .ADMode_1(ADMode_1), .ADMode_2(ADMode_2), .ADMode_3(ADMode_3),
    .ADMode1_1(ADMode1_1), .ADMode1_2(ADMode1_2), .ADMode1_3(ADMode1_3),
    .ADClk1(ADClk1), .ADClk2(ADClk2), .ADClk3(ADClk3),
    .Sout1(Sout1), .Sout2(Sout2), .Sout3(Sout3), .Sout4(Sout4),
    .ClkOut(ClkOut), .DataOut(DataOut),
    .ResCS3(ResCS3), .ResCS4(ResCS4), .ResCS5(ResCS5), .ResCS6(ResCS6), .ResCS7(ResCS7),
    .ResCS9(ResCS9), .ResClk(ResClk), .ResSDI1(ResSDI1), .ResSDI2(ResSDI2),
    .DebugP2(DebugP2), .DebugP3(DebugP3)
  );

  always #5 OSC_in = ~OSC_in;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ads(input int bitpos);
    for (int ch = 0; ch < 9; ch++) ads[ch] = adc_w[ch][bitpos];
  endtask

  // After release, Rst and all chip selects must hold for 16 ticks (64 cycles) of reset.
  task automatic check_reset_hold(input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      @(negedge OSC_in);
      if (Rst !== 1'b1 || cs_bus !== 6'h3F) bad = 1'b1;
    end
    chk({tag, "_hold"}, bad, 1'b0);
    @(negedge OSC_in);
    chk({tag, "_pot0_start"}, cs_bus, 6'h3E);
  endtask

  task automatic run_row(input int r);
    logic [7:0]   exp_rs;
    logic [107:0] got, exp_stream;
    logic         bad, prev;
    int           n, bits;
    exp_rs = 8'(1 << r);
    exp_stream = '0;
    for (int ch = 0; ch < 9; ch++) exp_stream = {exp_stream[95:0], adc_w[ch]};
    drive_ads(11);

    n = 0;
    while (rs_bus !== exp_rs && n < 3000) begin @(negedge OSC_in); n++; end
    chk("row_select", rs_bus, exp_rs);
    chk("frame_strobe", DebugP2, (r == 0));

    n = 0;
    while (PhaseA1 !== 1'b1 && n < 50) begin @(negedge OSC_in); n++; end
    chk("row_to_int_cycles", n, 8);

    n = 0; bad = 1'b0;
    while (PhaseA1 === 1'b1 && n < 400) begin
      if ({PhaseC1, PhaseC2, PhaseC3, PhaseC4} !== 4'b0) bad = 1'b1;
      if (PhaseA2 !== 1'b1 || PhaseA4 !== 1'b1 || rs_bus !== exp_rs) bad = 1'b1;
      @(negedge OSC_in); n++;
    end
    chk("int_cycles", n, 128);
    chk("int_clean", bad, 1'b0);

    n = 0; bad = 1'b0;
    while (PhaseC1 === 1'b1 && n < 100) begin
      if (PhaseA1 !== 1'b0 || {PhaseC2, PhaseC3, PhaseC4} !== 3'b111) bad = 1'b1;
      @(negedge OSC_in); n++;
    end
    chk("xfer_cycles", n, 16);
    chk("xfer_clean", bad, 1'b0);

    chk("conv_entry", {ADRst1, ADRst2, ADRst3, ADMode_1, ADMode_2, ADMode_3, DebugP3,
                       ADMode1_1}, 8'hFE);
    n = 0; bits = 0; bad = 1'b0; prev = ADClk1;
    while (ADMode_1 === 1'b1 && n < 300) begin
      if (DebugP3 !== 1'b1 || (n >= 4 && ADRst1 !== 1'b0)) bad = 1'b1;
      if (ADClk2 !== ADClk1 || ADClk3 !== ADClk1 || ADMode1_2 !== 1'b0) bad = 1'b1;
      if (ADClk1 === 1'b1 && prev === 1'b0) begin
        bits++;
        if (bits < 12) drive_ads(11 - bits);
      end
      prev = ADClk1;
      @(negedge OSC_in); n++;
    end
    chk("adc_clocks", bits, 12);
    chk("conv_cycles", n, 100);
    chk("conv_clean", bad, 1'b0);
    chk("sout_copy", sout_bus, {adc_w[3][0], adc_w[2][0], adc_w[1][0], adc_w[0][0]});
    chk("conv_exit_strobe", DebugP3, 1'b0);

    n = 0; bits = 0; got = '0; prev = ClkOut;
    while (rs_bus === exp_rs && n < 1500) begin
      if (ClkOut === 1'b1 && prev === 1'b0) begin
        got = {got[106:0], DataOut};
        bits++;
      end
      prev = ClkOut;
      @(negedge OSC_in); n++;
    end
    chk("out_pulses", bits, 108);
    chk("out_first_word", got[107:96], adc_w[0]);
    chk("out_stream", got, exp_stream);
  endtask

  initial begin
    logic [15:0] word;
    logic [5:0]  exp_cs;
    logic        bad, prev;
    int          n, bits;

    pushbutton = 1'b1;
    repeat (3) @(posedge OSC_in);
    @(negedge OSC_in);
    chk("reset_rst", Rst, 1'b1);
    chk("reset_cs", cs_bus, 6'h3F);
    chk("reset_rs", rs_bus, 8'h00);
    chk("reset_phases", {PhaseA1, PhaseA2, PhaseA4, PhaseC1, PhaseC2, PhaseC3, PhaseC4}, 7'h0);
    chk("reset_adrst", {ADRst1, ADRst2, ADRst3}, 3'b111);
    chk("reset_misc", {ClkOut, DataOut, ResClk, Clk1, Sin1, DebugP2, DebugP3, ADClk1}, 8'h0);
    pushbutton = 1'b0;
    check_reset_hold("por");

    for (int p = 0; p < 6; p++) begin
      exp_cs = ~(6'b1 << p);
      n = 0;
      while (cs_bus === 6'h3F && n < 100) begin @(negedge OSC_in); n++; end
      chk("pot_cs_select", cs_bus, exp_cs);
      n = 0; bits = 0; word = '0; bad = 1'b0; prev = ResClk;
      while (cs_bus === exp_cs && n < 400) begin
        if (ResClk === 1'b1 && prev === 1'b0) begin
          word = {word[14:0], ResSDI1};
          bits++;
        end
        if (ResSDI2 !== ResSDI1 || Rst !== 1'b1) bad = 1'b1;
        prev = ResClk;
        @(negedge OSC_in); n++;
      end
      chk("pot_word", word, 16'h0180);
      chk("pot_bits", bits, 16);
      chk("pot_cs_cycles", n, 128);
      chk("pot_clean", bad, 1'b0);
      chk("pot_cs_release", cs_bus, 6'h3F);
    end

    n = 0; bits = 0; word = '0; bad = 1'b0; prev = Clk1;
    while (Rst === 1'b1 && n < 400) begin
      if (Clk1 === 1'b1 && prev === 1'b0) begin
        word = {word[14:0], Sin1};
        bits++;
      end
      if (sin_all !== {15{Sin1}} || cfgclk_all !== {4{Clk1}} || cs_bus !== 6'h3F) bad = 1'b1;
      prev = Clk1;
      @(negedge OSC_in); n++;
    end
    chk("cfg_word", word, 16'hA5C3);
    chk("cfg_bits", bits, 16);
    chk("cfg_cycles_to_rst_fall", n, 132);
    chk("cfg_clean", bad, 1'b0);
    chk("cfg_idle", {cfgclk_all, sin_all}, 19'h0);
    chk("cfg_rs_idle", rs_bus, 8'h00);

    // Rows 0..7, then row 0 again to see the wrap and the second frame strobe.
    for (int k = 0; k < 9; k++) begin
      for (int ch = 0; ch < 9; ch++) adc_w[ch] = 12'($urandom);
      if (k == 0) begin
        adc_w[0] = 12'hABC;
        adc_w[8] = 12'hFFF;
      end
      run_row(k % 8);
    end

    n = 0;
    while (PhaseA1 !== 1'b1 && n < 100) begin @(negedge OSC_in); n++; end
    chk("midrst_in_int", PhaseA1, 1'b1);
    repeat (10) @(negedge OSC_in);
    pushbutton = 1'b1;
    @(negedge OSC_in);
    chk("midrst_rst", Rst, 1'b1);
    chk("midrst_phases", {PhaseA1, PhaseA2, PhaseA4, PhaseC1}, 4'h0);
    chk("midrst_rs", rs_bus, 8'h00);
    chk("midrst_cs", cs_bus, 6'h3F);
    chk("midrst_adc", {ADRst1, ADMode_1, DebugP3}, 3'b100);
    pushbutton = 1'b0;
    check_reset_hold("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
